// File: rtl/cbfp1_frame_ctrl_pkg.sv
// Shared types and constants for the stage-1 CBFP frame sequencer.
// The exponent entry layout is fixed here so the FIFO and controller agree on it.
package cbfp_pkg;

    localparam int NBLOCKS     = 2;
    localparam int IDX_W       = 5;
    localparam int FRAME_BEATS = 32;
    localparam int EXP_DEPTH   = 4;

    typedef struct packed {
        logic                             sof;
        logic                             eof;
        logic [NBLOCKS-1:0][IDX_W-1:0]    idx;
    } cbfp_exp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cbfp_st_e;

endpackage

// File: rtl/cbfp1_frame_ctrl_fifo.sv
// Synchronous exponent FIFO with registered occupancy and a synchronous clear.
// Head entry is forced to zero while empty so no stale data is presented.
module cbfp_exp_fifo
    import cbfp_pkg::*;
#(
    parameter int DEPTH = EXP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic                       i_wr_en,
    input  cbfp_exp_t                  i_wr_data,
    input  logic                       i_rd_en,
    output cbfp_exp_t                  o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cbfp_exp_t              r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   w_do_wr;
    logic                   w_do_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == {CNT_W{1'b0}});
    assign o_count   = r_count;
    assign w_do_rd   = i_rd_en && !o_empty;
    // A write into a full FIFO is only legal when the head leaves on the same edge.
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage, pointers (natural wrap at DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cbfp1_frame_ctrl.sv
// Stage-1 CBFP frame sequencer: accepts beats, tags sof/eof, queues exponents,
// and holds off the next frame until every exponent of the current one is popped.
module cbfp1_frame_ctrl #(
    parameter int NBLOCKS     = cbfp_pkg::NBLOCKS,
    parameter int IDX_W       = cbfp_pkg::IDX_W,
    parameter int FRAME_BEATS = cbfp_pkg::FRAME_BEATS,
    parameter int EXP_DEPTH   = cbfp_pkg::EXP_DEPTH
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NBLOCKS*IDX_W-1:0]          blk_idx_in,
    output logic                              cbfp_valid,
    output logic                              cbfp_sof,
    output logic                              cbfp_eof,
    output logic                              exp_valid,
    input  logic                              exp_ready,
    output logic [NBLOCKS*IDX_W-1:0]          exp_data,
    output logic                              exp_sof,
    output logic                              exp_eof,
    output logic [$clog2(FRAME_BEATS)-1:0]    beat_cnt,
    output logic                              frame_done
);

    import cbfp_pkg::*;

    localparam int                BEAT_W    = $clog2(FRAME_BEATS);
    localparam int                CNT_W     = $clog2(EXP_DEPTH) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

    cbfp_st_e           r_state;
    cbfp_st_e           w_state_nxt;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic               r_sof;
    logic               r_eof;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_pop;
    logic               w_accept;
    logic               w_in_ready;
    logic               w_frame_done;
    logic               w_first;
    logic               w_last;
    cbfp_exp_t          w_wr_entry;
    cbfp_exp_t          w_rd_entry;

    assign w_first = (r_beat_cnt == {BEAT_W{1'b0}});
    assign w_last  = (r_beat_cnt == LAST_BEAT);
    // clr takes priority: nothing is handed over or consumed in a clearing cycle.
    assign w_pop      = !w_empty && exp_ready && !clr;
    assign w_in_ready = rstn && !clr && (r_state != DRAIN) && (!w_full || w_pop);
    assign w_accept   = in_valid && w_in_ready;

    assign w_wr_entry.sof = w_first;
    assign w_wr_entry.eof = w_last;
    assign w_wr_entry.idx = blk_idx_in;

    cbfp_exp_fifo #(
        .DEPTH      (EXP_DEPTH)
    ) u_exp_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .i_wr_en    (w_accept),
        .i_wr_data  (w_wr_entry),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_rd_entry),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Next-state and frame_done decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? DRAIN : RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_accept && w_last) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DRAIN: begin
                if (w_count == {CNT_W{1'b0}}) begin
                    w_frame_done = !clr;
                    w_state_nxt  = IDLE;
                end else begin
                    w_state_nxt  = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter and sof/eof delayed to line up with the datapath valid_out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt <= {BEAT_W{1'b0}};
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else if (clr) begin
            r_beat_cnt <= {BEAT_W{1'b0}};
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            r_sof <= w_accept && w_first;
            r_eof <= w_accept && w_last;
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign cbfp_valid = w_accept;
    assign cbfp_sof   = r_sof;
    assign cbfp_eof   = r_eof;
    assign exp_valid  = !w_empty;
    assign exp_data   = w_rd_entry.idx;
    assign exp_sof    = w_rd_entry.sof;
    assign exp_eof    = w_rd_entry.eof;
    assign beat_cnt   = r_beat_cnt;
    assign frame_done = w_frame_done;

endmodule

// File: tb/tb_cbfp1_frame_ctrl.sv
// Randomised bench for cbfp1_frame_ctrl against a queue-based frame model,
// plus directed scenarios with hand-derived literal expectations.
module tb_cbfp1_frame_ctrl;

    localparam int FB = 32;
    localparam int ED = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  blk_idx_in;
    logic        cbfp_valid;
    logic        cbfp_sof;
    logic        cbfp_eof;
    logic        exp_valid;
    logic        exp_ready;
    logic [9:0]  exp_data;
    logic        exp_sof;
    logic        exp_eof;
    logic [4:0]  beat_cnt;
    logic        frame_done;

    cbfp1_frame_ctrl dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .blk_idx_in(blk_idx_in),
        .cbfp_valid(cbfp_valid), .cbfp_sof(cbfp_sof), .cbfp_eof(cbfp_eof),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .exp_sof(exp_sof), .exp_eof(exp_eof),
        .beat_cnt(beat_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: queued entries {sof, eof, idx}, next beat index, waiting-for-drain flag.
    logic [11:0] q[$];
    int          m_beat;
    bit          m_drain;
    bit          m_sof_d;
    bit          m_eof_d;
    bit          e_acc;
    bit          e_pop;
    bit          e_done;

    int          pop_n;
    int          sof_cnt;
    int          eof_at;
    logic [9:0]  first_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_beat  = 0;
        m_drain = 1'b0;
        m_sof_d = 1'b0;
        m_eof_d = 1'b0;
    endtask

    task automatic compare();
        int qn;
        bit ev;
        qn     = q.size();
        ev     = (qn > 0);
        e_pop  = ev && exp_ready && !clr && rstn;
        e_acc  = in_valid && rstn && !clr && !m_drain && (qn < ED || e_pop);
        e_done = m_drain && (qn == 0) && !clr;
        chk("exp_valid", {31'd0, exp_valid}, {31'd0, ev});
        if (ev) begin
            chk("exp_head", {20'd0, exp_sof, exp_eof, exp_data}, {20'd0, q[0]});
        end
        if (!clr) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, rstn && !m_drain && (qn < ED || e_pop)});
            chk("cbfp_valid", {31'd0, cbfp_valid}, {31'd0, e_acc});
            chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
        end
        chk("beat_cnt", {27'd0, beat_cnt}, m_beat);
        chk("cbfp_sof_eof", {30'd0, cbfp_sof, cbfp_eof}, {30'd0, m_sof_d, m_eof_d});
        if (e_pop) begin
            pop_n++;
            if (exp_sof) sof_cnt++;
            if (exp_eof) eof_at = pop_n;
            if (pop_n == 1) first_data = exp_data;
        end
    endtask

    task automatic model_advance();
        if (!rstn || clr) begin
            model_reset();
        end else begin
            if (e_pop) void'(q.pop_front());
            m_sof_d = e_acc && (m_beat == 0);
            m_eof_d = e_acc && (m_beat == FB - 1);
            if (e_acc) begin
                q.push_back({(m_beat == 0), (m_beat == FB - 1), blk_idx_in});
                if (m_beat == FB - 1) m_drain = 1'b1;
                m_beat = (m_beat + 1) % FB;
            end
            if (e_done) m_drain = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic r, input logic c, input logic [9:0] idx);
        @(negedge clk);
        in_valid   = v;
        exp_ready  = r;
        clr        = c;
        blk_idx_in = idx;
        #1;
        compare();
        model_advance();
    endtask

    // Full frame with exp_ready high and in_valid held across the boundary.
    task automatic run_frame(input string tag);
        logic rdy_a[36];
        logic fd_a[36];
        int   bc_a[36];
        int   fd_sum;
        pop_n = 0; sof_cnt = 0; eof_at = 0; first_data = 10'd0; fd_sum = 0;
        for (int i = 0; i < 36; i++) begin
            step(1'b1, 1'b1, 1'b0, {5'd3, 5'd7});
            rdy_a[i] = in_ready;
            fd_a[i]  = frame_done;
            bc_a[i]  = int'(beat_cnt);
            fd_sum  += int'(frame_done);
        end
        chk({tag, "_bc31"},         bc_a[31], 31);
        chk({tag, "_drain_rdy0"},   {31'd0, rdy_a[32]}, 32'd0);
        chk({tag, "_drain_rdy1"},   {31'd0, rdy_a[33]}, 32'd0);
        chk({tag, "_done_pos"},     {31'd0, fd_a[33]}, 32'd1);
        chk({tag, "_done_once"},    fd_sum, 1);
        chk({tag, "_bc_wrap"},      bc_a[33], 0);
        chk({tag, "_rdy_reopen"},   {31'd0, rdy_a[34]}, 32'd1);
        chk({tag, "_pops"},         pop_n, 33);
        chk({tag, "_sof_cnt"},      sof_cnt, 2);
        chk({tag, "_eof_at"},       eof_at, 32);
        chk({tag, "_first_data"},   {22'd0, first_data}, 32'h67);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk({tag, "_exp_valid"},  {31'd0, exp_valid}, 32'd0);
        chk({tag, "_sof_eof"},    {30'd0, cbfp_sof, cbfp_eof}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_in_ready"},   {31'd0, in_ready}, 32'd0);
        chk({tag, "_beat_cnt"},   {27'd0, beat_cnt}, 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 10'h155);
        @(negedge clk);
        rstn     = 1'b1;
        in_valid = 1'b0;
        exp_ready = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        int pr_v;
        int pr_r;
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; exp_ready = 1'b0; blk_idx_in = 10'd0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        chk("rst_exp_valid", {31'd0, exp_valid}, 32'd0);
        chk("rst_beat_cnt",  {27'd0, beat_cnt}, 32'd0);
        chk("rst_outputs",   {29'd0, cbfp_sof, cbfp_eof, frame_done}, 32'd0);
        rstn = 1'b1;

        run_frame("t1");

        // Backpressure: four accepts fill the FIFO, then in_ready drops.
        step(1'b0, 1'b0, 1'b1, 10'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 10'($urandom));
        chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t2_beat_cnt", {27'd0, beat_cnt}, 32'd4);
        // Full FIFO with push and pop together keeps one beat per cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 10'($urandom));
            chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
            chk("t3_beat_cnt", {27'd0, beat_cnt}, 4 + i);
            chk("t3_exp_valid", {31'd0, exp_valid}, 32'd1);
        end

        // Soft clear at beat 10 with three entries queued.
        step(1'b0, 1'b0, 1'b1, 10'd0);
        for (int i = 0; i < 10; i++) step(1'b1, (i < 8), 1'b0, 10'($urandom));
        step(1'b0, 1'b0, 1'b0, 10'd0);
        chk("t5_bc10", {27'd0, beat_cnt}, 32'd10);
        step(1'b1, 1'b1, 1'b1, 10'h3ff);
        step(1'b0, 1'b0, 1'b0, 10'd0);
        chk("t5_exp_valid", {31'd0, exp_valid}, 32'd0);
        chk("t5_beat_cnt",  {27'd0, beat_cnt}, 32'd0);
        chk("t5_no_done",   {31'd0, frame_done}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 10'h0a5);
        step(1'b0, 1'b0, 1'b0, 10'd0);
        chk("t5_cbfp_sof", {31'd0, cbfp_sof}, 32'd1);
        chk("t5_exp_sof",  {31'd0, exp_sof}, 32'd1);

        // Asynchronous reset in RUN with entries queued, then a clean frame.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 10'($urandom));
        async_reset("t6");
        run_frame("t6f");

        // Randomised traffic with varying pressure, rare clears and one reset.
        pr_v = 75; pr_r = 60;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                pr_v = $urandom_range(30, 100);
                pr_r = $urandom_range(5, 100);
            end
            if (n == 1500) async_reset("rnd_rst");
            step($urandom_range(0, 99) < pr_v, $urandom_range(0, 99) < pr_r,
                 $urandom_range(0, 149) == 0, 10'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
